// File: rtl/ram_bist_if.sv
// ram_bist_if: BIST control/result handshake plus RAM port bundle.
interface ram_bist_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              start;
  logic              ram_we;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ADDR_W-1:0] ram_addr;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] fail_data;
  modport master (
    output start, ram_q,
    input  ram_we, ram_addr, ram_data, busy, done, pass, fail_addr, fail_data
  );
  modport slave (
    input  start, ram_q,
    output ram_we, ram_addr, ram_data, busy, done, pass, fail_addr, fail_data
  );
endinterface

// File: rtl/ram_bist.sv
// ram_bist: write/read-back RAM self test with (addr + SEED) pattern and first-fail capture.
// Defining RAM_BIST_INV_EN adds a second pass with the bitwise-inverted pattern.
module ram_bist #(
  parameter int              ADDR_W = 5,
  parameter int              DATA_W = 8,
  parameter logic [DATA_W-1:0] SEED = DATA_W'(8'h01)
) (
  input  logic      clk,
  input  logic      reset,
  ram_bist_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, DONE} state_t;
  state_t            state_q;
  logic [ADDR_W-1:0] ram_addr_q, fail_addr_q, addr_d, cmp_addr;
  logic [DATA_W-1:0] ram_data_q, fail_data_q, inv_mask;
  logic              ram_we_q, busy_q, done_q, pass_q, last, fail_hit;
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return DATA_W'(a) + SEED;
  endfunction
`ifdef RAM_BIST_INV_EN
  logic inv_q;
  assign inv_mask = {DATA_W{inv_q}};
`else
  assign inv_mask = '0;
`endif
  assign addr_d   = ram_addr_q + ADDR_W'(1);
  // read data lags the address by one cycle; in CHECK the counter has wrapped so this yields DEPTH-1
  assign cmp_addr = ram_addr_q - ADDR_W'(1);
  assign last     = &ram_addr_q;
  assign fail_hit = (bus.ram_q != (pat(cmp_addr) ^ inv_mask)) &&
                    (state_q == CHECK || (state_q == READ && ram_addr_q != '0));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
`ifdef RAM_BIST_INV_EN
      inv_q       <= 1'b0;
`endif
    end else if (fail_hit) begin
      state_q     <= DONE;
      done_q      <= 1'b1;
      pass_q      <= 1'b0;
      fail_addr_q <= cmp_addr;
      fail_data_q <= bus.ram_q;
      ram_addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          state_q     <= WRITE;
          busy_q      <= 1'b1;
          ram_we_q    <= 1'b1;
          ram_addr_q  <= '0;
          ram_data_q  <= SEED;
          pass_q      <= 1'b0;
          fail_addr_q <= '0;
          fail_data_q <= '0;
`ifdef RAM_BIST_INV_EN
          inv_q       <= 1'b0;
`endif
        end
        WRITE: begin
          ram_addr_q <= addr_d;
          ram_we_q   <= !last;
          ram_data_q <= last ? '0 : pat(addr_d) ^ inv_mask;
          if (last) state_q <= READ;
        end
        READ: begin
          ram_addr_q <= addr_d;
          if (last) state_q <= CHECK;
        end
`ifdef RAM_BIST_INV_EN
        CHECK: if (!inv_q) begin
          inv_q      <= 1'b1;
          state_q    <= WRITE;
          ram_we_q   <= 1'b1;
          ram_data_q <= ~SEED;
        end else begin
          state_q <= DONE;
          done_q  <= 1'b1;
          pass_q  <= 1'b1;
        end
`else
        CHECK: begin
          state_q <= DONE;
          done_q  <= 1'b1;
          pass_q  <= 1'b1;
        end
`endif
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_data  = ram_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_addr = fail_addr_q;
  assign bus.fail_data = fail_data_q;
endmodule
